// File: rtl/dump_pkg.sv
// dump_pkg: shared states, phase encoding and stream-size constants for dump_sequencer
package dump_pkg;
    typedef enum logic [3:0] {
        IDLE, LOAD_PC, RB_REQ, RB_WAIT, DM_REQ, DM_WAIT, SEND, WAIT_TX, DONE, CHECKSUM
    } state_t;
    typedef enum logic [1:0] {PH_PC, PH_RB, PH_DM, PH_CK} phase_t;
    localparam int NB_BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W        = 2;
    localparam int WORD_CNT_W        = 5;
    localparam int NB_DUMP_BYTES     = NB_BYTES_PER_WORD * (1 + 32 + 32);
    localparam int NB_DUMP_BYTES_CK  = NB_DUMP_BYTES + 1;
endpackage

// File: rtl/word_serializer.sv
// word_serializer: shifts a loaded word out LSB byte first, one byte per send/advance handshake
module word_serializer import dump_pkg::*; #(
    parameter int BYTE  = 8,
    parameter int DWORD = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [DWORD-1:0] i_load_data,
    input  logic             i_send,
    input  logic             i_advance,
    output logic [BYTE-1:0]  o_tx_data,
    output logic             o_tx_start,
    output logic             o_last_byte
);
    logic [DWORD-1:0]      shift;
    logic [BYTE_CNT_W-1:0] cnt;
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            shift      <= '0;
            cnt        <= '0;
            o_tx_start <= 1'b0;
        end else begin
            o_tx_start <= i_send;
            if (i_clear || i_load) begin
                shift <= i_clear ? '0 : i_load_data;
                cnt   <= '0;
            end else if (i_advance) begin
                shift <= shift >> BYTE;
                cnt   <= cnt + 1'b1;
            end
        end
    end
    assign o_tx_data   = shift[BYTE-1:0];
    assign o_last_byte = cnt == BYTE_CNT_W'(NB_BYTES_PER_WORD - 1);
endmodule

// File: rtl/dump_sequencer.sv
// dump_sequencer: streams PC, R0..R31, M0..M31 bytewise to the UART; DUMP_CHECKSUM_EN appends an XOR checksum byte
module dump_sequencer import dump_pkg::*; #(
    parameter int BYTE        = 8,
    parameter int DWORD       = 32,
    parameter int RB_ADDR     = 5,
    parameter int DM_ADDR     = 5,
    parameter int NB_RB_WORDS = 32,
    parameter int NB_DM_WORDS = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_tx_done,
    input  logic [DWORD-1:0]   i_pc_value,
    input  logic [DWORD-1:0]   i_rb_data,
    input  logic [DWORD-1:0]   i_dm_data,
    output logic [RB_ADDR-1:0] o_rb_addr,
    output logic               o_rb_read_enable,
    output logic [DM_ADDR-1:0] o_dm_addr,
    output logic               o_dm_read_enable,
    output logic               o_dm_du_flag,
    output logic [BYTE-1:0]    o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_done
);
    localparam logic [WORD_CNT_W-1:0] LAST_RB = WORD_CNT_W'(NB_RB_WORDS - 1);
    localparam logic [WORD_CNT_W-1:0] LAST_DM = WORD_CNT_W'(NB_DM_WORDS - 1);
    state_t                state, nxt;
    phase_t                phase, nphase;
    logic [WORD_CNT_W-1:0] word, nword;
    logic                  load, adv, last_byte;
    logic [DWORD-1:0]      load_data;
`ifdef DUMP_CHECKSUM_EN
    logic [BYTE-1:0]       acc;
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) acc <= '0;
        else acc <= (i_abort || state == LOAD_PC) ? '0 : adv ? acc ^ o_tx_data : acc;
    end
`endif
    always_comb begin
        nxt       = state;
        nphase    = phase;
        nword     = word;
        load      = 1'b0;
        adv       = 1'b0;
        load_data = '0;
        case (state)
            IDLE: if (i_start) begin
                nxt    = LOAD_PC;
                nphase = PH_PC;
                nword  = '0;
            end
            LOAD_PC: begin
                load      = 1'b1;
                load_data = i_pc_value;
                nxt       = SEND;
            end
            RB_REQ: nxt = RB_WAIT;
            RB_WAIT: begin
                load      = 1'b1;
                load_data = i_rb_data;
                nxt       = SEND;
            end
            DM_REQ: nxt = DM_WAIT;
            DM_WAIT: begin
                load      = 1'b1;
                load_data = i_dm_data;
                nxt       = SEND;
            end
`ifdef DUMP_CHECKSUM_EN
            CHECKSUM: begin
                load      = 1'b1;
                load_data = DWORD'(acc);
                nxt       = SEND;
            end
`endif
            SEND: nxt = WAIT_TX;
            WAIT_TX: if (i_tx_done) begin
                adv = 1'b1;
                if (phase == PH_CK) nxt = DONE;
                else if (!last_byte) nxt = SEND;
                else if (phase == PH_PC) begin
                    nxt    = RB_REQ;
                    nphase = PH_RB;
                    nword  = '0;
                end else if (phase == PH_RB && word != LAST_RB) begin
                    nxt   = RB_REQ;
                    nword = word + 1'b1;
                end else if (phase == PH_RB) begin
                    nxt    = DM_REQ;
                    nphase = PH_DM;
                    nword  = '0;
                end else if (word != LAST_DM) begin
                    nxt   = DM_REQ;
                    nword = word + 1'b1;
                end else begin
`ifdef DUMP_CHECKSUM_EN
                    nxt    = CHECKSUM;
                    nphase = PH_CK;
                    nword  = '0;
`else
                    nxt = DONE;
`endif
                end
            end
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (i_abort) begin
            nxt    = IDLE;
            nphase = PH_PC;
            nword  = '0;
            load   = 1'b0;
            adv    = 1'b0;
        end
    end
    // outputs are registered from the next state so they align with the state they describe
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state            <= IDLE;
            phase            <= PH_PC;
            word             <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_rb_read_enable <= 1'b0;
            o_dm_read_enable <= 1'b0;
            o_rb_addr        <= '0;
            o_dm_addr        <= '0;
            o_dm_du_flag     <= 1'b0;
        end else begin
            state            <= nxt;
            phase            <= nphase;
            word             <= nword;
            o_busy           <= nxt != IDLE;
            o_done           <= nxt == DONE;
            o_rb_read_enable <= nxt == RB_REQ;
            o_dm_read_enable <= nxt == DM_REQ;
            o_rb_addr        <= i_abort ? '0 : nxt == RB_REQ ? RB_ADDR'(nword) : o_rb_addr;
            o_dm_addr        <= i_abort ? '0 : nxt == DM_REQ ? DM_ADDR'(nword) : o_dm_addr;
            o_dm_du_flag     <= nphase == PH_DM && nxt != DONE;
        end
    end
    word_serializer #(.BYTE(BYTE), .DWORD(DWORD)) u_ser (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_clear     (i_abort),
        .i_load      (load),
        .i_load_data (load_data),
        .i_send      (nxt == SEND),
        .i_advance   (adv),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_last_byte (last_byte)
    );
endmodule

// File: tb/tb_dump_sequencer.sv
// tb_dump_sequencer: directed bench with a stream-level byte model, UART and memory models
module tb_dump_sequencer;
`ifdef DUMP_CHECKSUM_EN
    localparam int NB_TOTAL = 261;
`else
    localparam int NB_TOTAL = 260;
`endif
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start, i_abort, i_tx_done;
    logic [31:0] i_pc_value, i_rb_data, i_dm_data;
    logic [4:0]  o_rb_addr, o_dm_addr;
    logic        o_rb_read_enable, o_dm_read_enable, o_dm_du_flag;
    logic [7:0]  o_tx_data;
    logic        o_tx_start, o_busy, o_done;

    logic [31:0] rb_mem [32];
    logic [31:0] dm_mem [32];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int checks = 0, fails = 0;
    int byte_idx = 0, done_cnt = 0, cyc = 0, td_cyc = 0, tx_cnt = 0;
    bit stuck = 0, prev_start = 0;

    dump_sequencer dut (
        .i_clock(clk), .i_reset(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_tx_done(i_tx_done), .i_pc_value(i_pc_value), .i_rb_data(i_rb_data),
        .i_dm_data(i_dm_data), .o_rb_addr(o_rb_addr), .o_rb_read_enable(o_rb_read_enable),
        .o_dm_addr(o_dm_addr), .o_dm_read_enable(o_dm_read_enable), .o_dm_du_flag(o_dm_du_flag),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: the dump is the little-endian byte image of PC, then RB, then DM, plus optional XOR byte
    task automatic build_exp();
        logic [31:0] words [$];
        logic [7:0]  x = 8'h00;
        exp_q.delete();
        words.push_back(i_pc_value);
        for (int k = 0; k < 32; k++) words.push_back(rb_mem[k]);
        for (int k = 0; k < 32; k++) words.push_back(dm_mem[k]);
        foreach (words[w])
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(words[w][8*b +: 8]);
                x ^= words[w][8*b +: 8];
            end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Monitor plus UART and memory models; all sampled/driven mid-cycle on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (o_tx_start) begin
                chk("tx_start_back_to_back", {31'b0, prev_start}, 0);
                if (exp_q.size() == 0) chk("tx_extra_byte", byte_idx, NB_TOTAL);
                else chk($sformatf("tx_byte[%0d]", byte_idx), o_tx_data, exp_q.pop_front());
                got_q.push_back(o_tx_data);
                chk("dm_du_flag", {31'b0, o_dm_du_flag}, (byte_idx >= 132 && byte_idx < 260) ? 1 : 0);
                if (!stuck && byte_idx > 0 && byte_idx < 260)
                    chk($sformatf("tx_gap[%0d]", byte_idx), cyc - td_cyc, (byte_idx % 4 == 0) ? 3 : 1);
                byte_idx++;
            end
            if (o_done) begin
                done_cnt++;
                if (!stuck) chk("done_latency", cyc - td_cyc, 1);
            end
            prev_start = o_tx_start;
            i_rb_data = rb_mem[o_rb_addr];
            i_dm_data = dm_mem[o_dm_addr];
            i_tx_done = stuck;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) i_tx_done = 1'b1;
            end
            if (o_tx_start) tx_cnt = 20;
            if (i_tx_done) td_cyc = cyc;
        end
    end

    task automatic start_dump(input string tag);
        build_exp();
        got_q.delete();
        byte_idx = 0;
        done_cnt = 0;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        chk({tag, "_busy_n1"}, {31'b0, o_busy}, 1);
        chk({tag, "_txs_n1"}, {31'b0, o_tx_start}, 0);
        @(negedge clk);
        chk({tag, "_txs_n2"}, {31'b0, o_tx_start}, 1);
    endtask

    task automatic run_dump(input string tag);
        int n = 0;
        start_dump(tag);
        while (!o_done && n < 20000) begin @(negedge clk); n++; end
        chk({tag, "_done_seen"}, {31'b0, o_done}, 1);
        @(negedge clk);
        chk({tag, "_busy_after_done"}, {31'b0, o_busy}, 0);
        repeat (2) @(negedge clk);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_bytes_left"}, exp_q.size(), 0);
        chk({tag, "_bytes_sent"}, got_q.size(), NB_TOTAL);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 32; k++) begin
            rb_mem[k] = 32'(k);
            dm_mem[k] = 32'hA500_0000 + 32'(k);
        end
        i_pc_value = 32'h0000_0040;
        rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {o_rb_addr, o_dm_addr, o_tx_data, o_rb_read_enable, o_dm_read_enable,
                              o_dm_du_flag, o_tx_start, o_busy, o_done}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_no_tx", {30'b0, o_tx_start, o_busy}, 0);
        end

        run_dump("base");
        chk("lit_pc", {got_q[0], got_q[1], got_q[2], got_q[3]}, 32'h4000_0000);
        chk("lit_r0", {got_q[4], got_q[5], got_q[6], got_q[7]}, 32'h0);
        chk("lit_m31", {got_q[256], got_q[257], got_q[258], got_q[259]}, 32'h1F00_00A5);
`ifdef DUMP_CHECKSUM_EN
        chk("lit_checksum", got_q[260], 8'h40);
`endif

        fork
            run_dump("dup_start");
            begin
                n = 0;
                while (!(o_rb_read_enable && o_rb_addr == 5'd10) && n < 20000) begin @(negedge clk); n++; end
                chk("reach_rb10", {31'b0, o_rb_read_enable}, 1);
                repeat (10) @(negedge clk);
                i_start = 1'b1;
                @(negedge clk);
                i_start = 1'b0;
            end
        join

        start_dump("abort");
        n = 0;
        while (!(o_dm_read_enable && o_dm_addr == 5'd5) && n < 20000) begin @(negedge clk); n++; end
        chk("reach_dm5", {31'b0, o_dm_read_enable}, 1);
        @(negedge clk); i_abort = 1'b1;
        @(negedge clk); i_abort = 1'b0;
        chk("abort_idle", {29'b0, o_busy, o_dm_du_flag, o_dm_read_enable}, 0);
        repeat (30) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_bytes", byte_idx, 152);
        chk("abort_still_idle", {31'b0, o_busy}, 0);
        @(negedge clk); i_start = 1'b1; i_abort = 1'b1;
        @(negedge clk); i_start = 1'b0; i_abort = 1'b0;
        chk("abort_beats_start", {31'b0, o_busy}, 0);
        run_dump("restart");

        start_dump("midreset");
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {o_rb_addr, o_dm_addr, o_tx_data, o_rb_read_enable, o_dm_read_enable,
                                 o_dm_du_flag, o_tx_start, o_busy, o_done}, 0);
        @(negedge clk); rst_n = 1'b1;
        exp_q.delete();
        tx_cnt = 0;
        repeat (25) @(negedge clk);
        chk("midreset_idle", {30'b0, o_busy, o_tx_start}, 0);

        stuck = 1'b1;
        run_dump("stuck");
        stuck = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
